// File: rtl/scaler_axis_cfggen_if.sv
// Configuration bundle for one scaler axis: size requests in, computed
// interpolation/crop results and status out.
interface scaler_axis_cfggen_if #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 12,
  parameter int DIV_W = 18
);
  logic [IN_W-1:0]  in_full_i;
  logic [OUT_W-1:0] out_size_i;
  logic [OUT_W-1:0] out_active_i;
  logic [1:0]       align_mode_i;
  logic [IN_W-1:0]  user_ofs_i;
  logic             cfg_req_i;

  logic [DIV_W-1:0] interp_factor_o;
  logic [IN_W-1:0]  in_needed_o;
  logic [IN_W-1:0]  in_first_o;
  logic [IN_W-1:0]  in_full_o;
  logic [OUT_W-1:0] out_size_o;
  logic             busy_o;
  logic             upd_o;
  logic             div0_o;

  // requester side
  modport master (
    output in_full_i, out_size_i, out_active_i, align_mode_i, user_ofs_i, cfg_req_i,
    input  interp_factor_o, in_needed_o, in_first_o, in_full_o, out_size_o,
           busy_o, upd_o, div0_o
  );

  // generator side
  modport slave (
    input  in_full_i, out_size_i, out_active_i, align_mode_i, user_ofs_i, cfg_req_i,
    output interp_factor_o, in_needed_o, in_first_o, in_full_o, out_size_o,
           busy_o, upd_o, div0_o
  );
endinterface

// File: rtl/scaler_axis_cfggen.sv
// Single-axis scaler configuration generator. Snapshots the size request,
// divides 2^(DIV_W-1) by out_size serially, scales by in_full*out_active in
// two registered multiplies, then clamps and aligns the crop window.
// Every result is published together on one edge with a one-cycle upd_o.
module scaler_axis_cfggen #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 12,
  parameter int DIV_W = 18
) (
  input logic              SYS_CLK,
  input logic              SYS_RST,
  scaler_axis_cfggen_if.slave cfg
);

  localparam int CNT_W = $clog2(DIV_W);
  localparam int P1_W  = DIV_W + IN_W;
  localparam int P2_W  = P1_W + OUT_W;
  localparam logic [DIV_W-1:0] DVD_INIT = {1'b1, {(DIV_W-1){1'b0}}};
  localparam logic [P2_W:0]    RND      = (P2_W+1)'(1) << (DIV_W-2);

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_MUL1, S_MUL2, S_POST, S_OUT} state_t;
  state_t state, state_nx;

  // request snapshot: operands for the whole job and the change-detect reference
  logic [IN_W-1:0]  snap_full, snap_ofs;
  logic [OUT_W-1:0] snap_size, snap_act;
  logic [1:0]       snap_align;
  logic             force_pend, req_pend;

  logic [OUT_W-1:0] rem;
  logic [DIV_W-1:0] quot, dvd;
  logic [CNT_W-1:0] cnt;
  logic [P1_W-1:0]  p1;
  logic [P2_W-1:0]  p2;
  logic [IN_W-1:0]  need_r, first_r;

  logic [DIV_W-1:0] f_q;
  logic [IN_W-1:0]  need_q, first_q, full_q;
  logic [OUT_W-1:0] size_q;
  logic             busy_q, upd_q, div0_q;

  logic             changed, start;
  logic [OUT_W:0]   rem_sh;
  logic             ge;
  logic [OUT_W-1:0] rem_nx;
  logic [DIV_W-1:0] f_eff;
  logic [P2_W:0]    p2_rnd, raw;
  logic [IN_W-1:0]  need_c, spare_c, first_c;

  // change detect, divider step, rounding/clamp/alignment
  always_comb begin
    changed = (cfg.in_full_i    != snap_full)  ||
              (cfg.out_size_i   != snap_size)  ||
              (cfg.out_active_i != snap_act)   ||
              (cfg.align_mode_i != snap_align) ||
              (cfg.user_ofs_i   != snap_ofs);
    start   = force_pend || req_pend || cfg.cfg_req_i || changed;

    rem_sh  = {rem, dvd[DIV_W-1]};
    ge      = rem_sh >= {1'b0, snap_size};
    rem_nx  = ge ? OUT_W'(rem_sh - {1'b0, snap_size}) : rem_sh[OUT_W-1:0];

    // divide by zero saturates the factor
    f_eff   = (snap_size == '0) ? '1 : quot;

    p2_rnd  = {1'b0, p2} + RND;
    raw     = p2_rnd >> (DIV_W-1);
    need_c  = (raw > {{(P2_W+1-IN_W){1'b0}}, snap_full}) ? snap_full : IN_W'(raw);
    spare_c = snap_full - need_c;
    first_c = '0;
    case (snap_align)
      2'd0:    first_c = spare_c >> 1;
      2'd1:    first_c = '0;
      2'd2:    first_c = spare_c;
      default: first_c = (snap_ofs < spare_c) ? snap_ofs : spare_c;
    endcase
  end

  // state register
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) state <= S_IDLE;
    else         state <= state_nx;
  end

  // next state: fixed-length walk through the pipeline once started
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_DIV;
      S_DIV:   if (cnt == CNT_W'(DIV_W-1)) state_nx = S_MUL1;
      S_MUL1:  state_nx = S_MUL2;
      S_MUL2:  state_nx = S_POST;
      S_POST:  state_nx = S_OUT;
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // datapath, pending flags and the published result registers
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      snap_full  <= '0; snap_size <= '0; snap_act <= '0;
      snap_align <= '0; snap_ofs  <= '0;
      force_pend <= 1'b1;
      req_pend   <= 1'b0;
      rem <= '0; quot <= '0; dvd <= '0; cnt <= '0;
      p1 <= '0; p2 <= '0; need_r <= '0; first_r <= '0;
      f_q <= '0; need_q <= '0; first_q <= '0; full_q <= '0; size_q <= '0;
      busy_q <= 1'b0; upd_q <= 1'b0; div0_q <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (state != S_IDLE && cfg.cfg_req_i) req_pend <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          snap_full  <= cfg.in_full_i;
          snap_size  <= cfg.out_size_i;
          snap_act   <= cfg.out_active_i;
          snap_align <= cfg.align_mode_i;
          snap_ofs   <= cfg.user_ofs_i;
          force_pend <= 1'b0;
          req_pend   <= 1'b0;
          busy_q     <= 1'b1;
          rem        <= '0;
          quot       <= '0;
          dvd        <= DVD_INIT;
          cnt        <= '0;
        end
        S_DIV: begin
          rem  <= rem_nx;
          quot <= {quot[DIV_W-2:0], ge};
          dvd  <= {dvd[DIV_W-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
        end
        S_MUL1: p1 <= P1_W'(f_eff) * P1_W'(snap_full);
        S_MUL2: p2 <= P2_W'(p1) * P2_W'(snap_act);
        S_POST: begin
          need_r  <= need_c;
          first_r <= first_c;
        end
        S_OUT: begin
          f_q     <= f_eff;
          need_q  <= need_r;
          first_q <= first_r;
          full_q  <= snap_full;
          size_q  <= snap_size;
          div0_q  <= (snap_size == '0);
          upd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cfg.interp_factor_o = f_q;
  assign cfg.in_needed_o     = need_q;
  assign cfg.in_first_o      = first_q;
  assign cfg.in_full_o       = full_q;
  assign cfg.out_size_o      = size_q;
  assign cfg.busy_o          = busy_q;
  assign cfg.upd_o           = upd_q;
  assign cfg.div0_o          = div0_q;

endmodule

// File: tb/tb_scaler_axis_cfggen.sv
// Bench for scaler_axis_cfggen: directed scenarios plus random configs,
// results compared against an arithmetic reference of the scaling rules.
module tb_scaler_axis_cfggen;
  localparam int IN_W  = 10;
  localparam int OUT_W = 12;
  localparam int DIV_W = 18;
  localparam int LAT   = DIV_W + 4;
  localparam int RES_W = DIV_W + 3*IN_W + OUT_W + 1;

  logic SYS_CLK = 1'b0;
  logic SYS_RST = 1'b1;
  always #5 SYS_CLK = ~SYS_CLK;

  scaler_axis_cfggen_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DIV_W(DIV_W)) bus ();

  scaler_axis_cfggen #(.IN_W(IN_W), .OUT_W(OUT_W), .DIV_W(DIV_W)) dut (
    .SYS_CLK (SYS_CLK),
    .SYS_RST (SYS_RST),
    .cfg     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge SYS_CLK) cyc <= cyc + 1;

  // monitor: edge index of busy rise / upd pulse, results latched at upd
  logic             busy_q = 1'b0;
  int               busy_rise = -1;
  int               upd_cnt = 0;
  int               upd_at = -1;
  logic [RES_W-1:0] m_res = '0;
  always @(posedge SYS_CLK) begin
    #1;
    if (bus.busy_o && !busy_q) busy_rise = cyc;
    busy_q = bus.busy_o;
    if (bus.upd_o) begin
      upd_cnt++;
      upd_at = cyc;
      m_res = {bus.interp_factor_o, bus.in_needed_o, bus.in_first_o,
               bus.in_full_o, bus.out_size_o, bus.div0_o};
    end
  end

  // reference: factor, clamped need, aligned first, echoes, div0
  function automatic logic [RES_W-1:0] expect_res(input int full, input int size,
      input int act, input int al, input int ofs);
    longint f, raw;
    int need, spare, first;
    bit d0;
    d0 = (size == 0);
    f = d0 ? (longint'(1) << DIV_W) - 1 : (longint'(1) << (DIV_W-1)) / size;
    raw = (f * longint'(full) * longint'(act) + (longint'(1) << (DIV_W-2))) >> (DIV_W-1);
    need = (raw > full) ? full : int'(raw);
    spare = full - need;
    case (al)
      0:       first = spare / 2;
      1:       first = 0;
      2:       first = spare;
      default: first = (ofs < spare) ? ofs : spare;
    endcase
    return {DIV_W'(f), IN_W'(need), IN_W'(first), IN_W'(full), OUT_W'(size), d0};
  endfunction

  task automatic set_cfg(input int full, input int size, input int act,
                         input int al, input int ofs);
    @(negedge SYS_CLK);
    bus.in_full_i    = IN_W'(full);
    bus.out_size_i   = OUT_W'(size);
    bus.out_active_i = OUT_W'(act);
    bus.align_mode_i = 2'(al);
    bus.user_ofs_i   = IN_W'(ofs);
  endtask

  task automatic wait_upd(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge SYS_CLK);
      if (upd_cnt > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int rel, base;
    bit ok;
    logic [RES_W-1:0] live, exp;
    SYS_RST = 1'b1;
    bus.cfg_req_i = 1'b0;
    set_cfg(240, 960, 960, 0, 0);
    repeat (3) @(negedge SYS_CLK);
    live = {bus.interp_factor_o, bus.in_needed_o, bus.in_first_o,
            bus.in_full_o, bus.out_size_o, bus.div0_o};
    checks++;
    if (live !== '0 || bus.busy_o !== 1'b0 || bus.upd_o !== 1'b0) begin
      errors++; $display("FAIL reset_state got %h busy %b upd %b want 0", live, bus.busy_o, bus.upd_o);
    end
    base = upd_cnt;
    SYS_RST = 1'b0;
    rel = cyc;
    wait_upd(base, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_timeout no upd got 0 want 1"); end
    checks++;
    if (busy_rise !== rel + 1) begin
      errors++; $display("FAIL reset_start got edge %0d want %0d", busy_rise, rel + 1);
    end
    checks++;
    if (upd_at - busy_rise !== LAT) begin
      errors++; $display("FAIL reset_latency got %0d want %0d", upd_at - busy_rise, LAT);
    end
    exp = expect_res(240, 960, 960, 0, 0);
    checks++;
    if (m_res !== exp || m_res[RES_W-1 -: DIV_W] !== DIV_W'(136)) begin
      errors++; $display("FAIL reset_result got %h want %h", m_res, exp);
    end
    repeat (30) @(negedge SYS_CLK);
    checks++;
    if (upd_cnt !== base + 1 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_single_upd got %0d busy %b want %0d", upd_cnt - base, bus.busy_o, 1);
    end
  endtask

  task automatic test_align();
    int base;
    bit ok;
    logic [RES_W-1:0] exp;
    for (int a = 0; a < 3; a++) begin
      base = upd_cnt;
      set_cfg(240, 480, 400, a, 0);
      wait_upd(base, ok);
      exp = expect_res(240, 480, 400, a, 0);
      checks++;
      if (!ok || m_res !== exp) begin
        errors++; $display("FAIL align%0d got %h want %h", a, m_res, exp);
      end
      repeat (30) @(negedge SYS_CLK);
      checks++;
      if (upd_cnt !== base + 1) begin
        errors++; $display("FAIL align%0d_upd_count got %0d want 1", a, upd_cnt - base);
      end
    end
  endtask

  task automatic test_user_ofs();
    int base;
    bit ok;
    int ofs [2] = '{50, 15};
    int want [2] = '{40, 15};
    for (int i = 0; i < 2; i++) begin
      base = upd_cnt;
      set_cfg(240, 480, 400, 3, ofs[i]);
      wait_upd(base, ok);
      checks++;
      if (!ok || m_res !== expect_res(240, 480, 400, 3, ofs[i]) || bus.in_first_o !== IN_W'(want[i])) begin
        errors++; $display("FAIL user_ofs%0d got first %0d res %h want first %0d", ofs[i], bus.in_first_o, m_res, want[i]);
      end
    end
  endtask

  task automatic test_div0();
    int base;
    bit ok;
    base = upd_cnt;
    set_cfg(240, 0, 400, 0, 0);
    wait_upd(base, ok);
    checks++;
    if (!ok || m_res !== expect_res(240, 0, 400, 0, 0) || bus.div0_o !== 1'b1) begin
      errors++; $display("FAIL div0_set got %h div0 %b want %h", m_res, bus.div0_o, expect_res(240, 0, 400, 0, 0));
    end
    base = upd_cnt;
    set_cfg(240, 480, 400, 0, 0);
    wait_upd(base, ok);
    checks++;
    if (!ok || bus.div0_o !== 1'b0 || m_res !== expect_res(240, 480, 400, 0, 0)) begin
      errors++; $display("FAIL div0_clear got %h div0 %b want 0", m_res, bus.div0_o);
    end
  endtask

  task automatic test_back_to_back();
    int base, old_rise, t, n;
    bit ok;
    base = upd_cnt;
    old_rise = busy_rise;
    set_cfg(240, 480, 400, 1, 0);
    n = 0;
    while (busy_rise == old_rise && n < 50) begin @(negedge SYS_CLK); n++; end
    t = busy_rise;
    while (cyc < t + 4) @(negedge SYS_CLK);
    bus.out_size_i = OUT_W'(960);
    while (cyc < t + 19) @(negedge SYS_CLK);
    bus.cfg_req_i = 1'b1;
    @(negedge SYS_CLK);
    bus.cfg_req_i = 1'b0;
    wait_upd(base, ok);
    checks++;
    if (!ok || upd_at !== t + LAT || m_res !== expect_res(240, 480, 400, 1, 0)) begin
      errors++; $display("FAIL b2b_first got %h at %0d want %h at %0d", m_res, upd_at, expect_res(240, 480, 400, 1, 0), t + LAT);
    end
    wait_upd(base + 1, ok);
    checks++;
    if (!ok || busy_rise !== t + LAT + 1 || m_res !== expect_res(240, 960, 400, 1, 0)) begin
      errors++; $display("FAIL b2b_second got %h start %0d want %h start %0d", m_res, busy_rise, expect_res(240, 960, 400, 1, 0), t + LAT + 1);
    end
    repeat (40) @(negedge SYS_CLK);
    checks++;
    if (upd_cnt !== base + 2) begin
      errors++; $display("FAIL b2b_upd_count got %0d want 2", upd_cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    int base, old_rise, n;
    bit ok;
    logic [RES_W-1:0] live;
    old_rise = busy_rise;
    set_cfg(240, 960, 960, 0, 0);
    n = 0;
    while (busy_rise == old_rise && n < 50) begin @(negedge SYS_CLK); n++; end
    repeat (5) @(negedge SYS_CLK);
    SYS_RST = 1'b1;
    #1;
    live = {bus.interp_factor_o, bus.in_needed_o, bus.in_first_o,
            bus.in_full_o, bus.out_size_o, bus.div0_o};
    checks++;
    if (live !== '0 || bus.busy_o !== 1'b0 || bus.upd_o !== 1'b0) begin
      errors++; $display("FAIL midreset_clear got %h busy %b want 0", live, bus.busy_o);
    end
    @(negedge SYS_CLK);
    base = upd_cnt;
    SYS_RST = 1'b0;
    wait_upd(base, ok);
    checks++;
    if (!ok || upd_at - busy_rise !== LAT || m_res !== expect_res(240, 960, 960, 0, 0)) begin
      errors++; $display("FAIL midreset_redo got %h lat %0d want %h lat %0d", m_res, upd_at - busy_rise, expect_res(240, 960, 960, 0, 0), LAT);
    end
  endtask

  task automatic test_random();
    int base, full, size, act, al, ofs;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      full = $urandom_range(1, 1023);
      size = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 4095);
      act  = $urandom_range(0, 4095);
      al   = $urandom_range(0, 3);
      ofs  = $urandom_range(0, 1023);
      base = upd_cnt;
      set_cfg(full, size, act, al, ofs);
      bus.cfg_req_i = 1'b1;
      @(negedge SYS_CLK);
      bus.cfg_req_i = 1'b0;
      wait_upd(base, ok);
      checks++;
      if (!ok || m_res !== expect_res(full, size, act, al, ofs)) begin
        errors++; $display("FAIL random%0d got %h want %h", i, m_res, expect_res(full, size, act, al, ofs));
      end
    end
  endtask

  initial begin
    bus.cfg_req_i = 1'b0;
    test_reset();
    test_align();
    test_user_ofs();
    test_div0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
